// File: rtl/status_reg.sv
// 6502-style processor status register (P).
// Six stored flags (N, V, D, I, Z, C); bit 5 and the B bit (bit 4) are not
// stored and always read back as 1.
// Three load sources are arbitrated here:
//   - a full byte from the internal bus (PLP/RTI), which beats everything
//   - ALU condition codes
//   - decoded SEC/CLC, SEI/CLI and SED/CLD values
// When the ALU and the decoded path both load C in the same cycle, the ALU
// carry is the value that is stored.
// Build option: define STATUS_TRISTATE_EN to release the output to 'z when
// oa=0. Without it the output is driven to 8'h00, so it can feed an OR/mux
// bus in FPGA fabric.
module status_reg #(
  parameter logic [7:0] RESET_VALUE = 8'h34
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] busin,
  input  logic       acary,
  input  logic       azero,
  input  logic       aoverflow,
  input  logic       aneg,
  input  logic       ircary,
  input  logic       irirqdis,
  input  logic       irdecmode,
  input  logic       wair,
  input  logic       waalu,
  input  logic       wabus,
  input  logic       oa,
  output logic [7:0] status
);

  logic r_n;
  logic r_v;
  logic r_d;
  logic r_i;
  logic r_z;
  logic r_c;

  logic [7:0] w_image;

  // Flag storage: reset is asynchronous and dominates every write enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n <= RESET_VALUE[7];
      r_v <= RESET_VALUE[6];
      r_d <= RESET_VALUE[3];
      r_i <= RESET_VALUE[2];
      r_z <= RESET_VALUE[1];
      r_c <= RESET_VALUE[0];
    end else if (wabus) begin
      // Bits 5:4 of the bus are ignored because they are not stored.
      r_n <= busin[7];
      r_v <= busin[6];
      r_d <= busin[3];
      r_i <= busin[2];
      r_z <= busin[1];
      r_c <= busin[0];
    end else begin
      if (waalu) begin
        r_n <= aneg;
        r_v <= aoverflow;
        r_z <= azero;
        r_c <= acary;
      end
      if (wair) begin
        r_d <= irdecmode;
        r_i <= irirqdis;
        // The decoded carry is used only when the ALU is not also loading C.
        if (!waalu) begin
          r_c <= ircary;
        end
      end
    end
  end

  // Assemble the P image; the unused bit and B always read as 1.
  always_comb begin
    w_image = {r_n, r_v, 1'b1, 1'b1, r_d, r_i, r_z, r_c};
  end

  // Output gating: the flops drive the output directly when oa=1.
`ifdef STATUS_TRISTATE_EN
  assign status = oa ? w_image : 8'hzz;
`else
  assign status = oa ? w_image : 8'h00;
`endif

endmodule

// File: tb/tb_status_reg.sv
// Directed testbench for status_reg, with expected values worked out by hand.
module tb_status_reg;

  logic       clk;
  logic       reset;
  logic [7:0] busin;
  logic       acary;
  logic       azero;
  logic       aoverflow;
  logic       aneg;
  logic       ircary;
  logic       irirqdis;
  logic       irdecmode;
  logic       wair;
  logic       waalu;
  logic       wabus;
  logic       oa;
  logic [7:0] status;

  int checks;
  int errors;

  status_reg #(.RESET_VALUE(8'h34)) dut (
    .clk       (clk),
    .reset     (reset),
    .busin     (busin),
    .acary     (acary),
    .azero     (azero),
    .aoverflow (aoverflow),
    .aneg      (aneg),
    .ircary    (ircary),
    .irirqdis  (irirqdis),
    .irdecmode (irdecmode),
    .wair      (wair),
    .waalu     (waalu),
    .wabus     (wabus),
    .oa        (oa),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_enables();
    wair  = 1'b0;
    waalu = 1'b0;
    wabus = 1'b0;
  endtask

  task automatic test_reset();
    oa    = 1'b1;
    wabus = 1'b1;
    busin = 8'hFF;
    reset = 1'b1;
    #1;
    checks++;
    if (status !== 8'h34) begin
      errors++;
      $display("FAIL reset_immediate: got %h expected %h", status, 8'h34);
    end
    tick();
    tick();
    checks++;
    if (status !== 8'h34) begin
      errors++;
      $display("FAIL reset_held_2clk: got %h expected %h", status, 8'h34);
    end
    clear_enables();
    busin = 8'h00;
    reset = 1'b0;
    tick();
    checks++;
    if (status !== 8'h34) begin
      errors++;
      $display("FAIL reset_release_hold: got %h expected %h", status, 8'h34);
    end
  endtask

  task automatic test_alu_load();
    waalu     = 1'b1;
    aneg      = 1'b1;
    aoverflow = 1'b1;
    azero     = 1'b0;
    acary     = 1'b1;
    tick();
    checks++;
    if (status !== 8'hF5) begin
      errors++;
      $display("FAIL alu_load: got %h expected %h", status, 8'hF5);
    end
    clear_enables();
    aneg = 1'b0; aoverflow = 1'b0; acary = 1'b0;
    tick();
    checks++;
    if (status !== 8'hF5) begin
      errors++;
      $display("FAIL alu_hold: got %h expected %h", status, 8'hF5);
    end
  endtask

  task automatic test_ir_load();
    // A short reset pulse between edges brings P back to 8'h34.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (status !== 8'h34) begin
      errors++;
      $display("FAIL ir_pre_reset: got %h expected %h", status, 8'h34);
    end
    wair      = 1'b1;
    ircary    = 1'b1;
    irirqdis  = 1'b0;
    irdecmode = 1'b1;
    tick();
    checks++;
    if (status !== 8'h39) begin
      errors++;
      $display("FAIL ir_load: got %h expected %h", status, 8'h39);
    end
    clear_enables();
  endtask

  task automatic test_bus_load();
    wabus = 1'b1;
    busin = 8'hC3;
    tick();
    checks++;
    if (status !== 8'hF3) begin
      errors++;
      $display("FAIL bus_load: got %h expected %h", status, 8'hF3);
    end
    wabus = 1'b0;
    busin = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (status !== 8'hF3) begin
        errors++;
        $display("FAIL bus_hold_%0d: got %h expected %h", k, status, 8'hF3);
      end
    end
    // Bits 5:4 of the bus are ignored: 8'h0C loads D=1, I=1 and clears the rest.
    wabus = 1'b1;
    busin = 8'h0C;
    tick();
    checks++;
    if (status !== 8'h3C) begin
      errors++;
      $display("FAIL bus_ignore_54: got %h expected %h", status, 8'h3C);
    end
    clear_enables();
  endtask

  task automatic test_priority();
    wabus     = 1'b1;
    busin     = 8'h00;
    waalu     = 1'b1;
    aneg      = 1'b1;
    aoverflow = 1'b1;
    azero     = 1'b1;
    acary     = 1'b1;
    tick();
    checks++;
    if (status !== 8'h30) begin
      errors++;
      $display("FAIL prio_bus_over_alu: got %h expected %h", status, 8'h30);
    end
    wabus     = 1'b0;
    aneg      = 1'b0;
    aoverflow = 1'b0;
    acary     = 1'b0;
    azero     = 1'b1;
    wair      = 1'b1;
    ircary    = 1'b1;
    irirqdis  = 1'b1;
    irdecmode = 1'b0;
    tick();
    checks++;
    if (status !== 8'h36) begin
      errors++;
      $display("FAIL prio_alu_ir: got %h expected %h", status, 8'h36);
    end
    // The bus also wins over the decoded set/clear path.
    wabus     = 1'b1;
    busin     = 8'hC1;
    waalu     = 1'b0;
    ircary    = 1'b0;
    irirqdis  = 1'b1;
    irdecmode = 1'b1;
    tick();
    checks++;
    if (status !== 8'hF1) begin
      errors++;
      $display("FAIL prio_bus_over_ir: got %h expected %h", status, 8'hF1);
    end
    // All three sources together: the bus still wins.
    busin     = 8'h36;
    waalu     = 1'b1;
    aneg      = 1'b1;
    acary     = 1'b1;
    tick();
    checks++;
    if (status !== 8'h36) begin
      errors++;
      $display("FAIL prio_all_three: got %h expected %h", status, 8'h36);
    end
    clear_enables();
  endtask

  task automatic test_oe_async();
    logic [7:0] exp_off;
`ifdef STATUS_TRISTATE_EN
    exp_off = 8'hzz;
`else
    exp_off = 8'h00;
`endif
    oa = 1'b0;
    #1;
    checks++;
    if (status !== exp_off) begin
      errors++;
      $display("FAIL oe_off: got %h expected %h", status, exp_off);
    end
    oa = 1'b1;
    #1;
    checks++;
    if (status !== 8'h36) begin
      errors++;
      $display("FAIL oe_on: got %h expected %h", status, 8'h36);
    end
    oa = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    oa = 1'b1;
    #1;
    checks++;
    if (status !== 8'h34) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", status, 8'h34);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    busin     = 8'h00;
    acary     = 1'b0;
    azero     = 1'b0;
    aoverflow = 1'b0;
    aneg      = 1'b0;
    ircary    = 1'b0;
    irirqdis  = 1'b0;
    irdecmode = 1'b0;
    wair      = 1'b0;
    waalu     = 1'b0;
    wabus     = 1'b0;
    oa        = 1'b1;
    #2;
    test_reset();
    test_alu_load();
    test_ir_load();
    test_bus_load();
    test_priority();
    test_oe_async();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
